// File: rtl/pll_reset_sequencer.sv
// Purpose: pulses the PLL reset, waits for a stable lock, then releases system reset; retries on timeout or lock loss.
// Latency: ready rises RST_PULSE_CYCLES+1+LOCK_STABLE_CYCLES edges after a restart when lock is already present.
// Backpressure: none; pll_locked and sw_reset_req are sampled every cycle and all outputs decode registered state.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int SYNC_STAGES         = 2,
    parameter int RETRY_W             = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               sw_reset_req,
    output logic               pll_rst,
    output logic               sys_reset,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_count
);

    // One shared counter sized for the longest interval; the timeout is at least 2,
    // so the width is always at least one bit.
    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABILIZE = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    logic [RETRY_W-1:0]     r_retry;
    logic                   w_retry_inc;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // Bring the asynchronous lock indication into the reference clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // State and shared interval counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Automatic-retry counter; holds at all-ones, only reset_n clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retry <= '0;
        end else if (w_retry_inc && !(&r_retry)) begin
            r_retry <= r_retry + RETRY_W'(1);
        end
    end

    // Next-state logic; a software restart outranks every lock event, and the
    // counter is cleared on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_retry_inc = 1'b0;
        if (sw_reset_req) begin
            w_state_nxt = S_RESET_PLL;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt = S_STABILIZE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == TO_LAST) begin
                        w_state_nxt = S_RESET_PLL;
                        w_cnt_nxt   = '0;
                        w_retry_inc = 1'b1;
                    end
                end
                S_STABILIZE: begin
                    // A lock dropout restarts the wait, not the whole attempt.
                    if (!w_lock_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == STAB_LAST) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                S_RUN: begin
                    w_cnt_nxt = '0;
                    if (!w_lock_s) begin
                        w_state_nxt = S_RESET_PLL;
                        w_retry_inc = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_RESET_PLL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decode the registered state only, so they glitch-free follow the async reset.
    assign pll_rst     = (r_state == S_RESET_PLL);
    assign sys_reset   = (r_state != S_RUN);
    assign ready       = (r_state == S_RUN);
    assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose: directed self-checking bench for pll_reset_sequencer with small timing parameters.
// Latency: outputs sampled 1 time unit after each rising edge; edge k counts from the release or stimulus point.
// Backpressure: none; stimulus is driven open-loop from fixed edge counts.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [3:0] retry_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .SYNC_STAGES        (2),
        .RETRY_W            (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .sw_reset_req(sw_reset_req),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .retry_count (retry_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Startup from RESET_PLL with lock present: pll_rst for 4 cycles, ready on edge 13.
    task automatic check_startup(input string tag, input logic [3:0] exp_retry);
        logic [6:0] exp;
        checks++;
        if ({pll_rst, sys_reset, ready, retry_count} !== {3'b110, exp_retry}) begin
            errors++;
            $display("FAIL %s pre-edge: got %b want %b", tag,
                     {pll_rst, sys_reset, ready, retry_count}, {3'b110, exp_retry});
        end
        for (int k = 1; k <= 13; k++) begin
            step();
            exp = {(k <= 3), (k < 13), (k >= 13), exp_retry};
            checks++;
            if ({pll_rst, sys_reset, ready, retry_count} !== exp) begin
                errors++;
                $display("FAIL %s edge %0d: {pll_rst,sys_reset,ready,retry} got %b want %b",
                         tag, k, {pll_rst, sys_reset, ready, retry_count}, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        pll_locked   = 1'b1;
        sw_reset_req = 1'b0;
        #12;
        checks++;
        if ({pll_rst, sys_reset, ready, retry_count} !== 7'b110_0000) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", {pll_rst, sys_reset, ready, retry_count}, 7'b110_0000);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_startup("startup", 4'd0);
    endtask

    task automatic test_lock_timeout();
        logic [6:0] exp;
        int         r;
        step();
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        step();
        reset_n = 1'b1;
        // Period is 4 reset cycles + 32 wait cycles; 17 periods cover saturation.
        for (int k = 1; k <= 612; k++) begin
            step();
            r   = (k / 36 > 15) ? 15 : k / 36;
            exp = {((k % 36) < 4), 1'b1, 1'b0, 4'(r)};
            checks++;
            if ({pll_rst, sys_reset, ready, retry_count} !== exp) begin
                errors++;
                $display("FAIL lock_timeout edge %0d: got %b want %b",
                         k, {pll_rst, sys_reset, ready, retry_count}, exp);
            end
        end
    endtask

    task automatic test_stabilize_glitch();
        logic [6:0] exp;
        step();
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        step();
        reset_n = 1'b1;
        // STABILIZE starts at edge 5; the one-cycle dropout reaches lock_s while cnt=5,
        // sending it back to WAIT_LOCK at edge 11, STABILIZE at 12, RUN at 20.
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = {(k <= 3), (k < 20), (k >= 20), 4'd0};
            checks++;
            if ({pll_rst, sys_reset, ready, retry_count} !== exp) begin
                errors++;
                $display("FAIL stabilize_glitch edge %0d: got %b want %b",
                         k, {pll_rst, sys_reset, ready, retry_count}, exp);
            end
            if (k == 8) pll_locked = 1'b0;
            if (k == 9) pll_locked = 1'b1;
        end
    endtask

    task automatic test_lock_loss();
        logic [6:0] exp;
        pll_locked = 1'b0;
        // RESET_PLL entered on edge 3 (two sync flops plus state flop); RUN again at edge 16.
        for (int k = 1; k <= 16; k++) begin
            step();
            exp = {(k >= 3 && k <= 6), (k >= 3 && k < 16), (k < 3 || k >= 16), (k >= 3) ? 4'd1 : 4'd0};
            checks++;
            if ({pll_rst, sys_reset, ready, retry_count} !== exp) begin
                errors++;
                $display("FAIL lock_loss edge %0d: got %b want %b",
                         k, {pll_rst, sys_reset, ready, retry_count}, exp);
            end
            if (k == 3) pll_locked = 1'b1;
        end
    endtask

    task automatic test_sw_reset();
        logic [6:0] exp;
        sw_reset_req = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) sw_reset_req = 1'b0;
            exp = {(k <= 4), (k < 14), (k >= 14), 4'd1};
            checks++;
            if ({pll_rst, sys_reset, ready, retry_count} !== exp) begin
                errors++;
                $display("FAIL sw_reset edge %0d: got %b want %b",
                         k, {pll_rst, sys_reset, ready, retry_count}, exp);
            end
        end
        // Request coincides with lock_s falling in RUN: restart without a retry increment.
        pll_locked = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp = {(k >= 3 && k <= 6), (k >= 3 && k < 16), (k < 3 || k >= 16), 4'd1};
            checks++;
            if ({pll_rst, sys_reset, ready, retry_count} !== exp) begin
                errors++;
                $display("FAIL sw_vs_lockloss edge %0d: got %b want %b",
                         k, {pll_rst, sys_reset, ready, retry_count}, exp);
            end
            if (k == 2) sw_reset_req = 1'b1;
            if (k == 3) begin
                sw_reset_req = 1'b0;
                pll_locked   = 1'b1;
            end
        end
    endtask

    task automatic test_async_reset();
        sw_reset_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 1) sw_reset_req = 1'b0;
        end
        checks++;
        if ({pll_rst, sys_reset, ready, retry_count} !== 7'b010_0001) begin
            errors++;
            $display("FAIL mid_stabilize: got %b want %b", {pll_rst, sys_reset, ready, retry_count}, 7'b010_0001);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pll_rst, sys_reset, ready, retry_count} !== 7'b110_0000) begin
            errors++;
            $display("FAIL async_reset: got %b want %b", {pll_rst, sys_reset, ready, retry_count}, 7'b110_0000);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_startup("restart", 4'd0);
    endtask

    initial begin
        test_reset();
        test_lock_timeout();
        test_stabilize_glitch();
        test_lock_loss();
        test_sw_reset();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
